// File: rtl/sfm_gate_gen_if.sv
// Bus bundle for the SFM gate generator: timestep start, phase references,
// switching-function outputs and status.
interface sfm_gate_gen_if;
  localparam int unsigned SINGLE_W = 32;

  logic                sta;
  logic [SINGLE_W-1:0] ma_single;
  logic [SINGLE_W-1:0] mb_single;
  logic [SINGLE_W-1:0] mc_single;
  logic [SINGLE_W-1:0] g1_single;
  logic [SINGLE_W-1:0] g3_single;
  logic [SINGLE_W-1:0] g5_single;
  logic                done_INV_SFM_g;
  logic                sta_err;

  modport master (
    output sta, ma_single, mb_single, mc_single,
    input  g1_single, g3_single, g5_single, done_INV_SFM_g, sta_err
  );

  modport slave (
    input  sta, ma_single, mb_single, mc_single,
    output g1_single, g3_single, g5_single, done_INV_SFM_g, sta_err
  );
endinterface

// File: rtl/sfm_gate_gen.sv
// Sine-triangle switching-function generator: compares three float references
// against a triangle carrier and emits 0.0/1.0 gate values once per timestep.
module sfm_gate_gen #(
  parameter int unsigned CARRIER_HALF = 100
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          rst_user,
  sfm_gate_gen_if.slave bus
);

  localparam int unsigned SW     = 32;
  localparam int unsigned MQ_W   = 18;
  localparam int unsigned OFF_W  = MQ_W + 1;
  localparam int unsigned CNT_W  = 16;
  localparam int unsigned PROD_W = 40;
  localparam int unsigned NPH    = 3;

  localparam logic [SW-1:0]    F_ONE   = 32'h3F80_0000;
  localparam logic [CNT_W-1:0] CNT_TOP = CNT_W'(CARRIER_HALF);
  localparam logic [MQ_W-1:0]  MQ_FULL = MQ_W'(65536);
  localparam logic [OFF_W-1:0] MQ_OFF  = OFF_W'(65536);

  typedef enum logic [1:0] {IDLE, CONV, CMP, DONE} state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              dir_dn_q, dir_dn_d;
  logic [SW-1:0]     ref_q [NPH];
  logic [SW-1:0]     ref_d [NPH];
  logic [MQ_W-1:0]   mq_q  [NPH];
  logic [MQ_W-1:0]   mq_d  [NPH];
  logic [NPH-1:0]    g_q, g_d;
  logic              done_q, done_d;
  logic              err_q, err_d;

  // Float -> two's complement m*2^16, truncated toward zero, saturated to +/-2^16
  function automatic logic [MQ_W-1:0] to_fixed(input logic [SW-1:0] f);
    logic [7:0]      e;
    logic [23:0]     mant;
    logic [MQ_W-1:0] mag;
    e    = f[30:23];
    mant = {1'b1, f[22:0]};
    if (e >= 8'd127) begin
      mag = MQ_FULL;
    end else if (e < 8'd111) begin
      mag = '0;
    end else begin
      mag = MQ_W'(mant >> (8'd134 - e));
    end
    return f[31] ? (MQ_W'(0) - mag) : mag;
  endfunction

  // (m_q + 2^16) * CARRIER_HALF > cnt * 2^17; both sides non-negative
  function automatic logic gate(input logic [MQ_W-1:0] mq, input logic [CNT_W-1:0] cnt);
    logic [OFF_W-1:0]  off;
    logic [PROD_W-1:0] lhs;
    logic [PROD_W-1:0] rhs;
    off = {mq[MQ_W-1], mq} + MQ_OFF;
    lhs = PROD_W'(off) * PROD_W'(CARRIER_HALF);
    rhs = PROD_W'(cnt) << 17;
    return lhs > rhs;
  endfunction

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      dir_dn_q <= 1'b0;
      g_q      <= '0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      for (int i = 0; i < NPH; i++) begin
        ref_q[i] <= '0;
        mq_q[i]  <= '0;
      end
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      dir_dn_q <= dir_dn_d;
      g_q      <= g_d;
      done_q   <= done_d;
      err_q    <= err_d;
      for (int i = 0; i < NPH; i++) begin
        ref_q[i] <= ref_d[i];
        mq_q[i]  <= mq_d[i];
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    dir_dn_d = dir_dn_q;
    g_d      = g_q;
    done_d   = 1'b0;
    err_d    = err_q;
    for (int i = 0; i < NPH; i++) begin
      ref_d[i] = ref_q[i];
      mq_d[i]  = mq_q[i];
    end

    if (bus.sta && (state_q != IDLE)) begin
      err_d = 1'b1;
    end

    unique case (state_q)
      IDLE: begin
        if (bus.sta) begin
          ref_d[0] = bus.ma_single;
          ref_d[1] = bus.mb_single;
          ref_d[2] = bus.mc_single;
          state_d  = CONV;
        end
      end
      CONV: begin
        for (int i = 0; i < NPH; i++) begin
          mq_d[i] = to_fixed(ref_q[i]);
        end
        state_d = CMP;
      end
      CMP: begin
        // Registered here so the new g values and the strobe appear during DONE
        for (int i = 0; i < NPH; i++) begin
          g_d[i] = gate(mq_q[i], cnt_q);
        end
        done_d  = 1'b1;
        state_d = DONE;
      end
      DONE: begin
        if (!dir_dn_q) begin
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_d == CNT_TOP) dir_dn_d = 1'b1;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
          if (cnt_d == '0) dir_dn_d = 1'b0;
        end
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Carrier phase re-init overrides the DONE advance
    if (rst_user) begin
      cnt_d    = '0;
      dir_dn_d = 1'b0;
    end
  end

  assign bus.g1_single      = g_q[0] ? F_ONE : '0;
  assign bus.g3_single      = g_q[1] ? F_ONE : '0;
  assign bus.g5_single      = g_q[2] ? F_ONE : '0;
  assign bus.done_INV_SFM_g = done_q;
  assign bus.sta_err        = err_q;

endmodule

// File: tb/tb_sfm_gate_gen.sv
// Self-checking bench for sfm_gate_gen: vector table, carrier sweeps,
// multi-cycle corner sequences and randomized steps against a reference model.
module tb_sfm_gate_gen;

  localparam int CH = 100;
  localparam logic [31:0] ONE  = 32'h3F800000;
  localparam logic [31:0] ZERO = 32'h00000000;

  logic clk;
  logic rst;
  logic rst_user;
  int   checks;
  int   failures;

  // Reference model state: step index along the carrier period, sticky error
  int   step_m;
  bit   err_m;

  sfm_gate_gen_if bus();

  sfm_gate_gen #(.CARRIER_HALF(CH)) dut (
    .clk      (clk),
    .rst      (rst),
    .rst_user (rst_user),
    .bus      (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] ma;
    logic [31:0] mb;
    logic [31:0] mc;
    logic [31:0] g1;
    logic [31:0] g3;
    logic [31:0] g5;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic int cnt_of(input int s);
    int p;
    p = s % (2 * CH);
    return (p <= CH) ? p : (2 * CH - p);
  endfunction

  function automatic longint model_fixed(input logic [31:0] f);
    int  e;
    real v;
    e = int'(f[30:23]);
    if (e == 255) return f[31] ? -64'sd65536 : 64'sd65536;
    if (e == 0) return 0;
    v = (1.0 + real'(f[22:0]) / 8388608.0) * (2.0 ** real'(e - 127)) * 65536.0;
    if (f[31]) v = -v;
    if (v >= 65536.0) return 65536;
    if (v <= -65536.0) return -65536;
    return longint'($rtoi(v));
  endfunction

  function automatic logic [31:0] model_g(input logic [31:0] f, input int cnt);
    longint lhs;
    longint rhs;
    lhs = (model_fixed(f) + 65536) * longint'(CH);
    rhs = longint'(cnt) * 131072;
    return (lhs > rhs) ? ONE : ZERO;
  endfunction

  // One timestep; optional extra sta in CONV and rst_user in DONE
  task automatic run_step(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c,
                          input bit sta_in_conv, input bit ru_in_done, input string name);
    logic [31:0] e1, e3, e5, o1, o3, o5;
    int lat;
    int ndone;
    e1 = model_g(a, cnt_of(step_m));
    e3 = model_g(b, cnt_of(step_m));
    e5 = model_g(c, cnt_of(step_m));
    lat = 0;
    ndone = 0;
    o1 = 'x; o3 = 'x; o5 = 'x;
    @(negedge clk);
    bus.sta = 1'b1;
    bus.ma_single = a;
    bus.mb_single = b;
    bus.mc_single = c;
    for (int i = 1; i <= 6; i++) begin
      @(negedge clk);
      bus.sta  = (i == 1) && sta_in_conv;
      rst_user = (i == 3) && ru_in_done;
      if (bus.done_INV_SFM_g) begin
        ndone++;
        if (lat == 0) begin
          lat = i;
          o1 = bus.g1_single;
          o3 = bus.g3_single;
          o5 = bus.g5_single;
        end
      end
    end
    if (sta_in_conv) err_m = 1'b1;
    chk({name, "_latency"}, 32'(lat), 32'd3);
    chk({name, "_ndone"}, 32'(ndone), 32'd1);
    chk({name, "_g1"}, o1, e1);
    chk({name, "_g3"}, o3, e3);
    chk({name, "_g5"}, o5, e5);
    chk({name, "_sta_err"}, 32'(bus.sta_err), 32'(err_m));
    step_m = ru_in_done ? 0 : step_m + 1;
  endtask

  task automatic pulse_rst_user();
    @(negedge clk);
    rst_user = 1'b1;
    @(negedge clk);
    rst_user = 1'b0;
    step_m = 0;
  endtask

  function automatic logic [31:0] rand_float();
    logic [31:0] sp [10];
    logic [31:0] r;
    sp = '{32'h00000000, 32'h80000000, 32'h00000001, 32'h7FC00000, 32'hFF800000,
           32'h3F800000, 32'hBF800000, 32'h40200000, 32'h3F000000, 32'h37800000};
    if ($urandom_range(0, 3) == 0) return sp[$urandom_range(0, 9)];
    r = $urandom;
    r[30:23] = 8'($urandom_range(108, 127));
    return r;
  endfunction

  initial begin
    vec_t tbl [5];
    int   nd;
    checks   = 0;
    failures = 0;
    step_m   = 0;
    err_m    = 1'b0;
    rst      = 1'b0;
    rst_user = 1'b0;
    bus.sta  = 1'b0;
    bus.ma_single = '0;
    bus.mb_single = '0;
    bus.mc_single = '0;

    // Vectors at carrier counts 0..4 after reset
    tbl[0] = '{32'h3F000000, 32'hBF800000, 32'h80000000, ONE,  ZERO, ONE };
    tbl[1] = '{32'hBF800000, 32'h7FC00000, 32'h00000000, ZERO, ONE,  ONE };
    tbl[2] = '{32'hBF7D70A4, 32'h40200000, 32'hFF800000, ZERO, ONE,  ZERO};
    tbl[3] = '{32'hBF700000, 32'hBF780000, 32'h00000001, ONE,  ZERO, ONE };
    tbl[4] = '{32'h3F800000, 32'h37800000, 32'hBF800001, ONE,  ONE,  ZERO};

    repeat (3) @(negedge clk);
    chk("rst_g1", bus.g1_single, ZERO);
    chk("rst_g3", bus.g3_single, ZERO);
    chk("rst_g5", bus.g5_single, ZERO);
    chk("rst_done", 32'(bus.done_INV_SFM_g), 32'd0);
    chk("rst_sta_err", 32'(bus.sta_err), 32'd0);
    rst = 1'b1;

    for (int i = 0; i < 5; i++) begin
      run_step(tbl[i].ma, tbl[i].mb, tbl[i].mc, 1'b0, 1'b0, $sformatf("vec%0d", i));
      chk($sformatf("vec%0d_tbl_g1", i), bus.g1_single, tbl[i].g1);
      chk($sformatf("vec%0d_tbl_g3", i), bus.g3_single, tbl[i].g3);
      chk($sformatf("vec%0d_tbl_g5", i), bus.g5_single, tbl[i].g5);
    end

    // Full carrier period: 0.5 / -1.0 / 2.5 against the stated thresholds
    pulse_rst_user();
    for (int k = 0; k < 2 * CH; k++) begin
      int c;
      c = (k <= CH) ? k : 2 * CH - k;
      run_step(32'h3F000000, 32'hBF800000, 32'h40200000, 1'b0, 1'b0, "sweep");
      chk($sformatf("sweep_g1_cnt%0d", c), bus.g1_single, (c >= 75) ? ZERO : ONE);
      chk($sformatf("sweep_g3_cnt%0d", c), bus.g3_single, ZERO);
      chk($sformatf("sweep_g5_cnt%0d", c), bus.g5_single, (c == CH) ? ZERO : ONE);
    end
    // Only cnt=0 yields 1 for m = -65535/65536
    run_step(32'hBF7FFF00, 32'h7FC00000, 32'h80000000, 1'b0, 1'b0, "wrap");
    chk("wrap_cnt0_g1", bus.g1_single, ONE);
    run_step(32'hBF7FFF00, 32'h00000001, 32'h00000000, 1'b0, 1'b0, "wrap1");
    chk("wrap_cnt1_g1", bus.g1_single, ZERO);

    // sta during CONV: ignored, flagged, single done
    run_step(32'h3F000000, 32'h00000000, 32'hBF000000, 1'b1, 1'b0, "busy_sta");
    chk("busy_sta_err", 32'(bus.sta_err), 32'd1);

    // rst during CMP aborts the step; sta ignored while in reset
    @(negedge clk);
    bus.sta = 1'b1;
    bus.ma_single = 32'h3F800000;
    @(negedge clk);
    bus.sta = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    bus.sta = 1'b1;
    @(negedge clk);
    rst = 1'b1;
    bus.sta = 1'b0;
    chk("abort_g1", bus.g1_single, ZERO);
    chk("abort_g3", bus.g3_single, ZERO);
    chk("abort_g5", bus.g5_single, ZERO);
    chk("abort_sta_err", 32'(bus.sta_err), 32'd0);
    nd = 0;
    for (int i = 0; i < 6; i++) begin
      if (bus.done_INV_SFM_g) nd++;
      @(negedge clk);
    end
    chk("abort_no_done", 32'(nd), 32'd0);
    step_m = 0;
    err_m  = 1'b0;

    // rst_user in DONE at cnt=37
    for (int i = 0; i < 37; i++) begin
      run_step(rand_float(), rand_float(), rand_float(), 1'b0, 1'b0, "pre37");
    end
    chk("pre37_cnt_model", 32'(cnt_of(step_m)), 32'd37);
    run_step(32'h3F000000, 32'h3F000000, 32'hBF7FFF00, 1'b0, 1'b1, "ru37");
    run_step(32'hBF7FFF00, 32'hBF7FFF00, 32'hBF7FFF00, 1'b0, 1'b0, "post_ru");
    chk("post_ru_cnt0_g1", bus.g1_single, ONE);
    run_step(32'hBF7FFF00, 32'hBF7FFF00, 32'hBF7FFF00, 1'b0, 1'b0, "post_ru1");
    chk("post_ru_cnt1_g1", bus.g1_single, ZERO);

    // Randomized steps against the model
    for (int i = 0; i < 250; i++) begin
      if ($urandom_range(0, 19) == 0) pulse_rst_user();
      run_step(rand_float(), rand_float(), rand_float(), 1'b0, 1'b0, "rnd");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sfm_gate_gen.md
SFM_GATE_GEN -- requirements
Module: sfm_gate_gen

Interface
REQ-001 SHALL have parameter CARRIER_HALF, default 100, meaning simulation steps per carrier half-period, with legal range 2..32767.
REQ-002 SHALL have port clk, input, 1 bit: the single system clock; all logic is rising-edge.
REQ-003 SHALL have port rst, input, 1 bit: reset, synchronous and active-low.
REQ-004 SHALL have port rst_user, input, 1 bit: user re-initialisation of the carrier phase, active-high, synchronous.
REQ-005 SHALL have port sta, input, 1 bit: one-cycle timestep start pulse.
REQ-006 SHALL have ports ma_single, mb_single, mc_single, input, `SINGLE bits each: phase a/b/c modulating references, IEEE-754 single, nominal range [-1,1].
REQ-007 SHALL have ports g1_single, g3_single, g5_single, output, `SINGLE bits each: switching functions of upper switches a/b/c, either 32'h3F800000 (1.0) or 32'h00000000 (0.0).
REQ-008 SHALL have port done_INV_SFM_g, output, 1 bit: one-cycle pulse marking that new g values are valid; this pulse is the FIFO write-strobe for the SFM source consumer.
REQ-009 SHALL have port sta_err, output, 1 bit: sticky flag set by an sta that arrives while the block is busy.

Function
REQ-010 SHALL implement the FSM IDLE -> CONV -> CMP -> DONE -> IDLE, one cycle per state; only IDLE accepts sta.
REQ-011 IDLE: sta=1 SHALL register ma/mb/mc and move to CONV; otherwise the FSM stays in IDLE.
REQ-012 CONV SHALL convert each reference to signed fixed-point m_q = trunc(m*2^16), saturated to [-65536, +65536].
REQ-013 Conversion boundaries SHALL be: biased exponent >= 127 clamps to ±65536 by sign; exponent < 111 (|m| < 2^-16, zero, or denormal) gives 0; Inf/NaN clamps to ±65536 by sign bit; -0 gives 0.
REQ-014 The carrier SHALL be an up/down counter cnt (16 bits) representing c = 2*cnt/CARRIER_HALF - 1, together with a direction bit dir.
REQ-015 CMP SHALL compute, per phase, gx = 1 iff (m_q + 65536)*CARRIER_HALF > cnt*131072, using exact integer arithmetic of at least 34 bits signed; equality SHALL give 0.
REQ-016 DONE SHALL update g1/g3/g5 for phases a/b/c and assert done_INV_SFM_g for exactly one cycle.
REQ-017 Latency: done_INV_SFM_g SHALL be high exactly 3 cycles after the cycle in which sta is sampled in IDLE; a new sta may be accepted in the cycle immediately after DONE.
REQ-018 In DONE the carrier SHALL advance: if dir is up, cnt increments, and on reaching CARRIER_HALF dir flips to down; if dir is down, cnt decrements, and on reaching 0 dir flips to up. The carrier is therefore a triangle 0..CARRIER_HALF..0 with no repeated end values.
REQ-019 g outputs SHALL hold their value between DONE cycles.
REQ-020 An sta while not in IDLE SHALL be ignored and SHALL set sta_err; sta_err SHALL clear only on rst.
REQ-021 rst_user=1 SHALL set cnt=0 and dir=up in any state. If it coincides with DONE, rst_user SHALL take precedence over the carrier advance, and the g outputs and done pulse of that DONE SHALL still occur.
REQ-022 The comparison SHALL use the cnt value before that cycle's advance.

Reset
REQ-023 While rst=0 at a clock edge: state=IDLE, cnt=0, dir=up, g1/g3/g5=32'h00000000, done_INV_SFM_g=0, sta_err=0, registered references=0.
REQ-024 rst asserted mid-operation SHALL abort the cycle with no done pulse and no carrier advance; sta SHALL be ignored while rst=0.

Verification
REQ-025 With CARRIER_HALF=100, after reset, ma=32'h3F000000 (0.5) and one sta -> done exactly 3 cycles later, g1=32'h3F800000, cnt becomes 1.
REQ-026 Sweep 200 sta pulses with ma=0.5 -> g1=0 exactly for the steps where cnt>=75 (the cnt=75 equality gives 0), g1=1.0 for all others; cnt returns to 0 after 200 steps and dir is up.
REQ-027 Apply mb=32'hBF800000 (-1.0) and mc=32'h40200000 (2.5, clamped to 1.0) over a full carrier period -> g3 is always 0; g5=1.0 except at cnt=100, where it is 0.
REQ-028 Apply mc=32'h7FC00000 (NaN) -> clamped to +1; mc=32'h00000001 (denormal) -> same result as 0.0 at each cnt; mc=32'h80000000 (-0) -> same as 0.0.
REQ-029 Pulse sta in the CONV cycle -> sta_err=1 and exactly one done pulse; assert rst=0 during CMP -> no done pulse, all outputs 0.
REQ-030 Assert rst_user during DONE at cnt=37 -> done pulse still asserted, following cnt=0 with dir up.
